multi_cycle_ctr: RTL and testbench
==================================

Name: multi_cycle_ctr

Overview:
- Moore FSM main controller for the multi-cycle MIPS datapath. It covers the same instruction subset as the single-cycle decoder: R-type, lw, sw, beq and j.
- It sequences a shared instruction/data memory, the IR, the register file, the ALU source muxes and PC update over 3-5 cycles per instruction.
- It supports a variable-latency memory through a memReady handshake.
- It sits between the IR opcode field and the datapath control inputs; the ALU-control block consumes aluOp.

Parameters:
- WAIT_MEM, 1: 1 means memory states hold until memReady=1. 0 means memReady is ignored and treated as 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opCode  in  6  IR[31:26]; valid from DECODE onward
- memReady  in  1  memory access completes this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if ALU zero
- iorD  out  1  memory address select: 0=PC, 1=ALUOut
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- irWrite  out  1  IR load
- memToReg  out  1  write-back select: 0=ALUOut, 1=MDR
- regDst  out  1  destination register select: 0=rt, 1=rd
- regWrite  out  1  register file write
- aluSrcA  out  1  ALU A select: 0=PC, 1=A
- aluSrcB  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
- aluOp  out  2  00=add, 01=sub, 10=funct
- pcSource  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- illegalOp  out  1  unsupported opcode seen in DECODE
- instrDone  out  1  one-cycle pulse on the last cycle of an instruction
- state  out  4  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10. Codes 11-15 are unused and go to FETCH on the next clock.
- Reset: asynchronous; state goes to IDLE immediately.
  - In IDLE every output is 0.
  - Reset asserted mid-instruction aborts the instruction immediately, with no further writes.
  - IDLE goes to FETCH on the first clock edge with reset=0.
- Outputs are decoded from state only. Exceptions: the memReady gating below, and illegalOp, which is decoded from state plus opCode. Any output not listed for a state is 0.
- FETCH:
  - Drives memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite=pcWrite=memReady.
  - Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE:
  - Drives aluSrcA=0, aluSrcB=11, aluOp=00.
  - Dispatch on opCode: 000000 -> EXECUTE; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP.
  - Any other opcode: illegalOp=1 for this cycle, next state FETCH, no datapath write.
- MEM_ADDR: drives aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEM_READ if opCode=100011, otherwise MEM_WRITE.
- MEM_READ: drives memRead=1, iorD=1. Holds until memReady=1, then goes to MEM_WB.
- MEM_WB: drives regDst=0, memToReg=1, regWrite=1, instrDone=1. Goes to FETCH.
- MEM_WRITE:
  - Drives iorD=1, memWrite=1.
  - Holds with memWrite=1 while memReady=0.
  - On memReady=1: instrDone=1 and next state FETCH.
- EXECUTE: drives aluSrcA=1, aluSrcB=00, aluOp=10. Goes to R_WB.
- R_WB: drives regDst=1, memToReg=0, regWrite=1, instrDone=1. Goes to FETCH.
- BRANCH: drives aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1. Goes to FETCH.
- JUMP: drives pcWrite=1, pcSource=10, instrDone=1. Goes to FETCH.
- opCode must stay stable from DECODE to the end of the instruction; the IR is written only in FETCH.
- Latency with memReady tied to 1: lw 5 cycles; sw and R-type 4; beq and j 3. Each memory wait cycle adds 1.
- With WAIT_MEM=0, a memReady=0 input has no effect on transitions or gating.
- At most one of memRead and memWrite is 1 in any cycle. regWrite and memWrite are never 1 together.

Test Plan:
- Reset held, then released with opCode=000000 and memReady=1 -> all outputs 0 during reset. State sequence 1,2,7,8,1. regWrite=1 with regDst=1 only in state 8. instrDone high for exactly one cycle.
- opCode=100011, memReady low for 2 cycles in FETCH and 3 cycles in MEM_READ -> FETCH lasts 3 cycles with irWrite=0 until the last. MEM_READ lasts 4 cycles. Total 10 cycles. regWrite and memToReg are 1 only in MEM_WB.
- opCode=101011, memReady=1 -> states 1,2,3,6,1. memWrite=1 for exactly one cycle with iorD=1. regWrite is never 1.
- beq (000100), then j (000010) -> each takes 3 cycles. beq: pcWriteCond=1, aluOp=01, pcSource=01 in state 9. j: pcWrite=1, pcSource=10 in state 10.
- opCode=111111 -> illegalOp=1 in DECODE only. Next state FETCH. No regWrite, memWrite or pcWrite besides the one in FETCH.
- Reset asserted asynchronously mid-MEM_WRITE, between clock edges -> state=0 and memWrite=0 immediately. First clock edge after release enters FETCH.

Source files
------------

// File: rtl/multi_cycle_ctr.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctr
//
// Main controller for the multi-cycle MIPS datapath (R-type, lw, sw, beq, j).
// A Moore FSM steps each instruction through 3-5 states and drives the
// datapath control lines for a shared instruction/data memory, the IR, the
// register file, the ALU source muxes and the PC update.
//
// Handshake: a memory access is presented by memRead or memWrite together with
// iorD. The memory raises memReady in the cycle the access completes. The
// controller holds the memory state until memReady=1 is seen at the clock edge.
// The writes that complete with the access (irWrite and pcWrite in FETCH, and
// instrDone in MEM_WRITE) are gated by memReady in that same cycle. With
// WAIT_MEM=0, memReady is ignored and every access completes in one cycle.
//
// Parameters:
//   WAIT_MEM     1: memory states hold until memReady=1; 0: memReady ignored
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (state -> IDLE at once)
//   opCode       IR[31:26], valid from DECODE to the end of the instruction
//   memReady     memory access completes this cycle
//   pcWrite      unconditional PC load
//   pcWriteCond  PC load if ALU zero
//   iorD         memory address select: 0=PC, 1=ALUOut
//   memRead      memory read strobe
//   memWrite     memory write strobe
//   irWrite      IR load
//   memToReg     write-back select: 0=ALUOut, 1=MDR
//   regDst       destination register select: 0=rt, 1=rd
//   regWrite     register file write
//   aluSrcA      ALU A select: 0=PC, 1=A
//   aluSrcB      ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2
//   aluOp        00=add, 01=sub, 10=funct
//   pcSource     PC source: 00=ALU, 01=ALUOut, 10=jump target
//   illegalOp    unsupported opcode seen in DECODE
//   instrDone    one-cycle pulse on the last cycle of an instruction
//   state        current state encoding, for debug
// -----------------------------------------------------------------------------
module multi_cycle_ctr #(
    parameter bit WAIT_MEM = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       illegalOp,
    output logic       instrDone,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10
    } state_t;

    // Control lines that depend on the state alone.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_t state_q;
    state_t state_d;
    ctl_t   ctl_q;
    logic   mem_ok;
    logic   in_fetch;
    logic   in_decode;
    logic   in_mem_write;
    logic   legal_op;

    // With WAIT_MEM=0 every access is treated as completing immediately.
    assign mem_ok = WAIT_MEM ? memReady : 1'b1;

    function automatic state_t next_state(input state_t s,
                                          input logic [5:0] op,
                                          input logic ok);
        state_t n;
        n = FETCH;
        case (s)
            IDLE:      n = FETCH;
            FETCH:     n = ok ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_RTYPE:     n = EXECUTE;
                    OP_LW, OP_SW: n = MEM_ADDR;
                    OP_BEQ:       n = BRANCH;
                    OP_J:         n = JUMP;
                    default:      n = FETCH;  // illegal opcode: drop it
                endcase
            end
            MEM_ADDR:  n = (op == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  n = ok ? MEM_WB : MEM_READ;
            MEM_WB:    n = FETCH;
            MEM_WRITE: n = ok ? FETCH : MEM_WRITE;
            EXECUTE:   n = R_WB;
            R_WB:      n = FETCH;
            BRANCH:    n = FETCH;
            JUMP:      n = FETCH;
            default:   n = FETCH;  // unused codes recover through FETCH
        endcase
        return n;
    endfunction

    function automatic ctl_t moore_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ior_d     = 1'b0;
                c.alu_src_a = 1'b0;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                // Branch target computed speculatively while decoding.
                c.alu_src_a = 1'b0;
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                c.mem_read = 1'b1;
                c.ior_d    = 1'b1;
            end
            MEM_WB: begin
                c.reg_dst    = 1'b0;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                c.ior_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                c.reg_dst    = 1'b1;
                c.mem_to_reg = 1'b0;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.instr_done    = 1'b1;
            end
            JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_JUMP;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = next_state(state_q, opCode, mem_ok);
    end

    // The control register is loaded from the decode of the next state, so
    // it always equals the Moore decode of state_q while being a flop output.
    // Reset clears both at once, which forces every output low in IDLE and
    // aborts any in-flight write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= moore_ctl(state_d);
        end
    end

    assign in_fetch     = (state_q == FETCH);
    assign in_decode    = (state_q == DECODE);
    assign in_mem_write = (state_q == MEM_WRITE);

    assign legal_op = (opCode == OP_RTYPE) || (opCode == OP_LW) ||
                      (opCode == OP_SW)    || (opCode == OP_BEQ) ||
                      (opCode == OP_J);

    // IR load and PC+4 commit only in the cycle the fetch read completes.
    assign irWrite     = in_fetch & mem_ok;
    assign pcWrite     = ctl_q.pc_write | (in_fetch & mem_ok);
    assign pcWriteCond = ctl_q.pc_write_cond;
    assign iorD        = ctl_q.ior_d;
    assign memRead     = ctl_q.mem_read;
    assign memWrite    = ctl_q.mem_write;
    assign memToReg    = ctl_q.mem_to_reg;
    assign regDst      = ctl_q.reg_dst;
    assign regWrite    = ctl_q.reg_write;
    assign aluSrcA     = ctl_q.alu_src_a;
    assign aluSrcB     = ctl_q.alu_src_b;
    assign aluOp       = ctl_q.alu_op;
    assign pcSource    = ctl_q.pc_source;
    assign illegalOp   = in_decode & ~legal_op;
    // A store finishes in the cycle its write is accepted.
    assign instrDone   = ctl_q.instr_done | (in_mem_write & mem_ok);
    assign state       = state_q;

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// Testbench for multi_cycle_ctr: a per-cycle vector table for the main
// instruction flows, followed by hand-written sequences for asynchronous reset
// during a store and for the WAIT_MEM=0 variant.
module tb_multi_cycle_ctr;

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] opCode = 6'd0;
    logic memReady = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (WAIT_MEM=1) ----------------
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegalOp, instrDone;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    multi_cycle_ctr #(.WAIT_MEM(1'b1)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .illegalOp(illegalOp), .instrDone(instrDone),
        .state(state)
    );

    // ---------------- DUT (WAIT_MEM=0) ----------------
    logic       nw_pcWrite, nw_pcWriteCond, nw_iorD, nw_memRead, nw_memWrite;
    logic       nw_irWrite, nw_memToReg, nw_regDst, nw_regWrite, nw_aluSrcA;
    logic       nw_illegalOp, nw_instrDone;
    logic [1:0] nw_aluSrcB, nw_aluOp, nw_pcSource;
    logic [3:0] nw_state;

    multi_cycle_ctr #(.WAIT_MEM(1'b0)) dut_nw (
        .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
        .pcWrite(nw_pcWrite), .pcWriteCond(nw_pcWriteCond), .iorD(nw_iorD),
        .memRead(nw_memRead), .memWrite(nw_memWrite), .irWrite(nw_irWrite),
        .memToReg(nw_memToReg), .regDst(nw_regDst), .regWrite(nw_regWrite),
        .aluSrcA(nw_aluSrcA), .aluSrcB(nw_aluSrcB), .aluOp(nw_aluOp),
        .pcSource(nw_pcSource), .illegalOp(nw_illegalOp),
        .instrDone(nw_instrDone), .state(nw_state)
    );

    // Output word order:
    // pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst
    // regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] pcSource[1:0] illegalOp instrDone
    logic [17:0] act_outs;
    assign act_outs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                       memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
                       pcSource, illegalOp, instrDone};

    function automatic logic [17:0] ow(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rd,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] aop, input logic [1:0] psrc, input logic ill,
        input logic done);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop,
                psrc, ill, done};
    endfunction

    // Hand-derived expected output words, one per (state, gating) case.
    logic [17:0] O_IDLE, O_FW, O_FG, O_DEC, O_DEC_ILL, O_MADDR, O_MRD, O_MWB;
    logic [17:0] O_MWW, O_MWG, O_EXE, O_RWB, O_BR, O_JMP;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] outs;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [5:0] op,
                                input logic rdy, input logic [3:0] st,
                                input logic [17:0] outs);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.outs = outs;
        vecs.push_back(v);
    endfunction

    // Drive inputs on the falling edge, sample 1 time unit later.
    task automatic drive(input logic rst, input logic [5:0] op, input logic rdy);
        @(negedge clk);
        reset = rst; opCode = op; memReady = rdy;
        #1;
    endtask

    initial begin
        //                 pcw pcwc iord mr mw irw m2r rd rw asa asb    aop    psrc   ill done
        O_IDLE    = '0;
        O_FW      = ow(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
        O_FG      = ow(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
        O_DEC     = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        O_DEC_ILL = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1, 0);
        O_MADDR   = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
        O_MRD     = ow(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        O_MWB     = ow(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        O_MWW     = ow(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        O_MWG     = ow(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        O_EXE     = ow(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
        O_RWB     = ow(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        O_BR      = ow(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1);
        O_JMP     = ow(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 1);

        // Reset held, then R-type: 1,2,7,8
        add(1, R, 1, 0, O_IDLE);
        add(1, R, 1, 0, O_IDLE);
        add(0, R, 1, 0, O_IDLE);
        add(0, R, 1, 1, O_FG);
        add(0, R, 1, 2, O_DEC);
        add(0, R, 1, 7, O_EXE);
        add(0, R, 1, 8, O_RWB);
        // lw with 2 fetch waits and 3 read waits: 10 cycles
        add(0, LW, 0, 1, O_FW);
        add(0, LW, 0, 1, O_FW);
        add(0, LW, 1, 1, O_FG);
        add(0, LW, 1, 2, O_DEC);
        add(0, LW, 1, 3, O_MADDR);
        add(0, LW, 0, 4, O_MRD);
        add(0, LW, 0, 4, O_MRD);
        add(0, LW, 0, 4, O_MRD);
        add(0, LW, 1, 4, O_MRD);
        add(0, LW, 1, 5, O_MWB);
        // sw, no waits: 1,2,3,6
        add(0, SW, 1, 1, O_FG);
        add(0, SW, 1, 2, O_DEC);
        add(0, SW, 1, 3, O_MADDR);
        add(0, SW, 1, 6, O_MWG);
        // sw with one write wait
        add(0, SW, 1, 1, O_FG);
        add(0, SW, 1, 2, O_DEC);
        add(0, SW, 1, 3, O_MADDR);
        add(0, SW, 0, 6, O_MWW);
        add(0, SW, 1, 6, O_MWG);
        // beq then j: 3 cycles each
        add(0, BEQ, 1, 1, O_FG);
        add(0, BEQ, 1, 2, O_DEC);
        add(0, BEQ, 1, 9, O_BR);
        add(0, JMP, 1, 1, O_FG);
        add(0, JMP, 1, 2, O_DEC);
        add(0, JMP, 1, 10, O_JMP);
        // illegal opcode: DECODE flags it, back to FETCH
        add(0, BAD, 1, 1, O_FG);
        add(0, BAD, 1, 2, O_DEC_ILL);
        add(0, R, 1, 1, O_FG);
        add(0, R, 1, 2, O_DEC);
        add(0, R, 1, 7, O_EXE);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].rdy);
            check($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("row%0d_outs", i), 32'(act_outs), 32'(vecs[i].outs));
            check($sformatf("row%0d_rd_wr_excl", i), 32'(memRead & memWrite), 32'd0);
            check($sformatf("row%0d_rw_mw_excl", i), 32'(regWrite & memWrite), 32'd0);
        end

        // Async reset in the middle of a stalled store.
        drive(0, SW, 1);
        check("ar_rwb", 32'(state), 32'd8);
        drive(0, SW, 1);
        check("ar_fetch", 32'(state), 32'd1);
        drive(0, SW, 1);
        check("ar_decode", 32'(state), 32'd2);
        drive(0, SW, 1);
        check("ar_maddr", 32'(state), 32'd3);
        drive(0, SW, 0);
        check("ar_mw_state", 32'(state), 32'd6);
        check("ar_mw_memwrite", 32'(memWrite), 32'd1);
        @(posedge clk);
        #2;
        check("ar_still_mw", 32'(state), 32'd6);
        reset = 1'b1;
        #1;
        check("ar_state_now", 32'(state), 32'd0);
        check("ar_memwrite_now", 32'(memWrite), 32'd0);
        check("ar_outs_now", 32'(act_outs), 32'd0);
        @(posedge clk);
        #1;
        check("ar_held", 32'(state), 32'd0);
        drive(0, R, 1);
        check("ar_released", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        check("ar_first_fetch", 32'(state), 32'd1);

        // WAIT_MEM=0 ignores memReady=0; WAIT_MEM=1 instance stalls in FETCH.
        drive(1, R, 0);
        check("nw_reset", 32'(nw_state), 32'd0);
        drive(0, R, 0);
        @(posedge clk);
        #1;
        check("nw_fetch", 32'(nw_state), 32'd1);
        check("nw_irwrite", 32'(nw_irWrite), 32'd1);
        check("nw_pcwrite", 32'(nw_pcWrite), 32'd1);
        check("w_fetch_irwrite", 32'(irWrite), 32'd0);
        @(posedge clk);
        #1;
        check("nw_decode", 32'(nw_state), 32'd2);
        check("w_stalled", 32'(state), 32'd1);
        @(posedge clk);
        #1;
        check("nw_execute", 32'(nw_state), 32'd7);
        @(posedge clk);
        #1;
        check("nw_rwb", 32'(nw_state), 32'd8);
        check("nw_done", 32'(nw_instrDone), 32'd1);
        @(posedge clk);
        #1;
        check("nw_back_fetch", 32'(nw_state), 32'd1);
        check("w_still_fetch", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
